// File: rtl/instr_fetch_pkg.sv
// Core-wide constants: NOP word, base opcodes, instruction types
// and the fetch FSM encoding.
package instr_fetch_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ITYPE_R  = 3'd0,
        ITYPE_I  = 3'd1,
        ITYPE_S  = 3'd2,
        ITYPE_SB = 3'd3,
        ITYPE_U  = 3'd4,
        ITYPE_UJ = 3'd5
    } itype_t;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2,
        FS_ERR  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns PC and IR, fetches over req/ack,
// and commits the next PC when the control unit retires an instruction.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            pc_update,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic            i_mem_req,
    output logic [XLEN-1:0] i_mem_addr,
    input  logic            i_mem_ack,
    input  logic [31:0]     i_mem_rdata,
    output logic [31:0]     ir,
    output logic [6:0]      opcode,
    output logic            ir_valid,
    output logic [XLEN-1:0] pc,
    output logic [63:0]     instret,
    output logic            fetch_err
);

    localparam logic [7:0] WD_MAX = 8'(TIMEOUT);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [7:0]      wd;
    logic [7:0]      wd_inc;
    logic [XLEN-1:0] pc_nxt;
    logic            misaligned;
    logic            timed_out;

    assign wd_inc     = wd + 8'd1;
    assign timed_out  = (wd_inc == WD_MAX);
    assign pc_nxt     = pc_src ? branch_target : pc + XLEN'(4);
    assign misaligned = (pc_nxt[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst_n) state <= FS_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FS_IDLE: if (fetch_en) state_nxt = FS_REQ;
            FS_REQ: begin
                if (i_mem_ack)      state_nxt = FS_HOLD;
                else if (timed_out) state_nxt = FS_ERR;
            end
            FS_HOLD: begin
                if (pc_update)
                    state_nxt = misaligned ? FS_ERR : FS_IDLE;
            end
            FS_ERR:  state_nxt = FS_ERR;
            default: state_nxt = FS_ERR;
        endcase
    end

    always_comb begin
        i_mem_req  = (state == FS_REQ);
        ir_valid   = (state == FS_HOLD);
        i_mem_addr = pc;
        opcode     = ir[6:0];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc        <= RESET_PC;
            ir        <= NOP_WORD;
            instret   <= '0;
            fetch_err <= 1'b0;
            wd        <= '0;
        end else begin
            unique case (state)
                FS_IDLE: if (fetch_en) wd <= '0;
                FS_REQ: begin
                    if (i_mem_ack) begin
                        ir <= i_mem_rdata;
                    end else begin
                        wd <= wd_inc;
                        if (timed_out) fetch_err <= 1'b1;
                    end
                end
                FS_HOLD: begin
                    // a misaligned target still lands in pc for debug
                    if (pc_update) begin
                        pc      <= pc_nxt;
                        instret <= instret + 64'd1;
                        if (misaligned) fetch_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fetch scoreboard.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        pc_update;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        i_mem_req;
    logic [63:0] i_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic        ir_valid;
    logic [63:0] pc;
    logic [63:0] instret;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [63:0] m_pc;
    logic [63:0] m_instret;

    instr_fetch #(
        .XLEN    (64),
        .RESET_PC(64'h0),
        .TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_en     (fetch_en),
        .pc_update    (pc_update),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .i_mem_req    (i_mem_req),
        .i_mem_addr   (i_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .ir           (ir),
        .opcode       (opcode),
        .ir_valid     (ir_valid),
        .pc           (pc),
        .instret      (instret),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        m_pc = 64'h0;
        m_instret = 64'h0;
        sb.delete();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, pc, 64'h0);
        chk({tag, "_ir"}, {32'h0, ir}, {32'h0, NOP_WORD});
        chk({tag, "_opc"}, {57'h0, opcode}, {57'h0, OPC_OP_IMM});
        chk({tag, "_irv"}, {63'h0, ir_valid}, 64'h0);
        chk({tag, "_req"}, {63'h0, i_mem_req}, 64'h0);
        chk({tag, "_addr"}, i_mem_addr, 64'h0);
        chk({tag, "_iret"}, instret, 64'h0);
        chk({tag, "_err"}, {63'h0, fetch_err}, 64'h0);
    endtask

    // fetch one word; the memory acks ack_dly cycles after req appears
    task automatic do_fetch(input logic [31:0] word, input int ack_dly);
        exp_t e;
        sb.push_back('{addr: m_pc, word: word});
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk("req_up", {63'h0, i_mem_req}, 64'h1);
        chk("req_addr", i_mem_addr, sb[0].addr);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk("req_hold", {63'h0, i_mem_req}, 64'h1);
        end
        i_mem_ack = 1'b1;
        i_mem_rdata = word;
        tick();
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'hdead_beef;
        chk("irv_up", {63'h0, ir_valid}, 64'h1);
        chk("req_down", {63'h0, i_mem_req}, 64'h0);
        e = sb.pop_front();
        chk("ir", {32'h0, ir}, {32'h0, e.word});
        chk("opcode", {57'h0, opcode}, {57'h0, e.word[6:0]});
        chk("pc_hold", pc, e.addr);
    endtask

    task automatic commit(input logic src, input logic [63:0] tgt);
        pc_update = 1'b1;
        pc_src = src;
        branch_target = tgt;
        tick();
        pc_update = 1'b0;
        pc_src = 1'b0;
        m_pc = src ? tgt : m_pc + 64'd4;
        m_instret = m_instret + 64'd1;
        chk("pc_next", pc, m_pc);
        chk("irv_down", {63'h0, ir_valid}, 64'h0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b1;
        fetch_en = 1'b0;
        pc_update = 1'b0;
        pc_src = 1'b0;
        branch_target = 64'h0;
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'h0;
        tick();
        do_reset();
        check_reset_state("rst");

        do_fetch(32'h0050_0093, 1);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk("hold_fen_irv", {63'h0, ir_valid}, 64'h1);
        chk("hold_fen_req", {63'h0, i_mem_req}, 64'h0);
        commit(1'b0, 64'h0);
        chk("instret1", instret, m_instret);

        do_fetch(32'h0020_81b3, 0);
        commit(1'b1, 64'h100);
        chk("instret2", instret, m_instret);

        do_fetch(32'h0000_0463, 3);
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h1234_5678;
        tick();
        i_mem_ack = 1'b0;
        chk("ack_hold_ir", {32'h0, ir}, 64'h0000_0463);
        commit(1'b0, 64'h0);
        chk("instret3", instret, m_instret);
        chk("err_none", {63'h0, fetch_err}, 64'h0);

        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        cnt = 0;
        while (i_mem_req === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
        chk("to_cycles", 64'(cnt), 64'd255);
        chk("to_err", {63'h0, fetch_err}, 64'h1);
        chk("to_req", {63'h0, i_mem_req}, 64'h0);
        fetch_en = 1'b1;
        tick();
        tick();
        fetch_en = 1'b0;
        chk("err_fen_req", {63'h0, i_mem_req}, 64'h0);
        chk("err_irv", {63'h0, ir_valid}, 64'h0);
        do_reset();
        check_reset_state("rst2");

        do_fetch(32'h0000_006f, 2);
        commit(1'b1, 64'h102);
        chk("mis_err", {63'h0, fetch_err}, 64'h1);
        fetch_en = 1'b1;
        tick();
        tick();
        fetch_en = 1'b0;
        chk("mis_req", {63'h0, i_mem_req}, 64'h0);
        chk("mis_pc", pc, 64'h102);
        do_reset();

        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk("mid_req", {63'h0, i_mem_req}, 64'h1);
        rst_n = 1'b1;
        tick();
        chk("mid_req_drop", {63'h0, i_mem_req}, 64'h0);
        rst_n = 1'b0;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'hcafe_f00d;
        tick();
        i_mem_ack = 1'b0;
        check_reset_state("late_ack");
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage of the multicycle RISC-V core, directly upstream of the control unit.
- Owns the PC and the instruction register (IR), and fetches from instruction memory through a req/ack handshake.
- Presents opcode/IR/PC to the control unit and datapath.
- Commits the next PC (sequential or redirect) when the control unit finishes an instruction.

Parameters:
- XLEN, 64: PC and address width.
- RESET_PC, 0: PC value after reset.
- TIMEOUT, 255: max cycles waiting for i_mem_ack before flagging error (8-bit watchdog).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-high (name kept per codebase; asserted = 1)
- fetch_en  in  1  control unit in fetch state; request a new instruction
- pc_update  in  1  one-cycle strobe at end of instruction (writeback)
- pc_src  in  1  1 = redirect to branch_target, 0 = PC+4
- branch_target  in  XLEN  redirect address from datapath
- i_mem_req  out  1  instruction memory request
- i_mem_addr  out  XLEN  request address
- i_mem_ack  in  1  memory data valid this cycle
- i_mem_rdata  in  32  instruction word
- ir  out  32  instruction register
- opcode  out  7  ir[6:0], feeds control unit
- ir_valid  out  1  IR holds a freshly fetched instruction
- pc  out  XLEN  address of instruction in IR
- instret  out  64  retired-instruction counter
- fetch_err  out  1  sticky: timeout or misaligned PC

Behaviour:
- Reset values (rst_n = 1 at a clk edge):
  - pc = RESET_PC; ir = 32'h00000013 (NOP); opcode = 7'b0010011.
  - ir_valid = 0, i_mem_req = 0, i_mem_addr = RESET_PC, instret = 0, fetch_err = 0.
  - watchdog = 0; state IDLE.
- Reset overrides everything, including mid-request: i_mem_req drops at the reset edge, and a late ack is ignored.
- FSM states: IDLE, REQ, HOLD, ERR.
- IDLE:
  - fetch_en = 1 → REQ; i_mem_req = 1 and i_mem_addr = pc from the next cycle.
  - pc_update is ignored.
- REQ:
  - i_mem_req and i_mem_addr are held stable until ack.
  - Ack may arrive in the same cycle req is first seen.
  - On i_mem_ack: ir <= i_mem_rdata, ir_valid <= 1, i_mem_req <= 0 → HOLD.
  - Watchdog increments each REQ cycle without ack. Reaching TIMEOUT → fetch_err <= 1, i_mem_req <= 0 → ERR.
  - fetch_en and pc_update are ignored.
- HOLD:
  - IR, opcode and pc stay stable for the whole instruction.
  - Further fetch_en is ignored.
  - On pc_update:
    - pc <= pc_src ? branch_target : pc + 4 (mod 2^XLEN, wraps silently).
    - instret <= instret + 1; ir_valid <= 0 → IDLE.
  - If the selected next PC has bits [1:0] != 0: pc is still updated, fetch_err <= 1 → ERR.
- ERR:
  - Stays until reset; i_mem_req = 0, ir_valid = 0.
  - IR keeps its last value; all inputs are ignored.
- Simultaneous events:
  - fetch_en and pc_update in the same cycle act per the current state only.
  - i_mem_ack outside REQ is ignored.
- Latency: fetch_en sampled at cycle t → i_mem_req high at t+1. Ack sampled at cycle k → ir_valid high at k+1. Minimum fetch_en-to-ir_valid is 2 cycles.
- opcode is always ir[6:0] (combinational from the register).
- The watchdog clears on entry to REQ.

Decomposition:
- Shared package (core-wide):
  - NOP word 32'h00000013.
  - Opcode constants (R 0110011, LOAD 0000011, OP-IMM 0010011, STORE 0100011, BRANCH 1100011, AUIPC 0010111, JAL 1101111), also used by the control unit.
  - Instruction-type codes (R = 0 … UJ = 5).
  - Fetch FSM state encoding.
- Sub-module: none required. The watchdog is an inline counter; PC next-value logic stays in this module.

Test Plan:
- Reset then fetch_en = 1, memory acks 1 cycle after req with 32'h00500093 → i_mem_addr = 0, ir = 32'h00500093, opcode = 7'b0010011, ir_valid = 1, pc = 0.
- In HOLD, pc_update = 1, pc_src = 0 → pc = 4, instret = 1, ir_valid = 0. Next fetch uses i_mem_addr = 4.
- In HOLD, pc_update = 1, pc_src = 1, branch_target = 64'h100 → pc = 64'h100. Next req address is 64'h100.
- Memory never acks → after 255 REQ cycles fetch_err = 1, i_mem_req = 0. fetch_en is then ignored until rst_n = 1, which restores pc = 0 and fetch_err = 0.
- Redirect to 64'h102 → fetch_err = 1, FSM in ERR, no further i_mem_req.
- rst_n = 1 while in REQ, with ack arriving the cycle after → i_mem_req = 0, ir stays NOP, ir_valid = 0, the late ack is ignored, and pc = RESET_PC.
